// File: rtl/rtc_stopwatch_lap.sv
// rtc_stopwatch_lap: BCD stopwatch with start/stop/lap/clear buttons, a small
// lap memory with recall, and a multiplexed active-low 7-segment display.
// o_dbg_state encoding: 0 = IDLE, 1 = RUN, 2 = STOP. o_dbg_count is the live
// count. i_dbg_load overwrites the count on the next edge and takes priority
// over a tick.
module rtc_stopwatch_lap #(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 100,
    parameter int NUM_DIGITS = 6,
    parameter int TIME_FMT   = 1,
    parameter int LAP_DEPTH  = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    i_startstop,
    input  logic                    i_lap,
    input  logic                    i_clear,
    input  logic                    i_dbg_load,
    input  logic [4*NUM_DIGITS-1:0] i_dbg_value,
    output logic [7:0]              o_segments,
    output logic [NUM_DIGITS-1:0]   o_digits,
    output logic                    o_running,
    output logic [3:0]              o_lap_count,
    output logic                    o_overflow,
    output logic [1:0]              o_dbg_state,
    output logic [4*NUM_DIGITS-1:0] o_dbg_count
);
    localparam int CW        = 4 * NUM_DIGITS;
    localparam int PRESC_DIV = CLK_HZ / TICK_HZ;
    localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW        = $clog2(NUM_DIGITS);
    localparam int VW        = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_sync1, r_sync2, r_sync3;   // bit0 startstop, bit1 lap, bit2 clear
    logic [PW-1:0]       r_presc;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_laps [LAP_DEPTH];
    logic [3:0]          r_lap_count;
    logic                r_view;
    logic [VW-1:0]       r_view_idx;
    logic                r_overflow;
    logic [SW-1:0]       r_scan_cnt;
    logic [DW-1:0]       r_scan_dig;
    logic [NUM_DIGITS-1:0] r_digits;
    logic [7:0]          r_segments;

    logic [2:0]          w_evt;
    logic                w_tick;
    logic [CW-1:0]       w_next_count;
    logic                w_wrap;
    logic [CW-1:0]       w_disp_value;
    logic [3:0]          w_disp_digit;
    logic                w_dp_on;
    logic [7:0]          w_seg_next;

    function automatic logic [3:0] digit_max(input int idx);
        if (TIME_FMT == 1 && (idx == 3 || idx == 5)) digit_max = 4'd5;
        else                                         digit_max = 4'd9;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Button synchronisers; the third stage gives the previous level for edge detection.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= {i_clear, i_lap, i_startstop};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_evt  = r_sync2 & ~r_sync3;
    assign w_tick = (r_state == S_RUN) && (r_presc == PW'(PRESC_DIV - 1));

    // Ripple-carry BCD increment; a digit at or above its maximum wraps to 0 and carries.
    always_comb begin
        logic v_carry;
        v_carry      = 1'b1;
        w_next_count = r_count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_carry) begin
                if (r_count[4*i +: 4] >= digit_max(i)) begin
                    w_next_count[4*i +: 4] = 4'd0;
                end else begin
                    w_next_count[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    v_carry = 1'b0;
                end
            end
        end
        w_wrap = v_carry;
    end

    // Control FSM: lap is judged in the pre-transition state, then start/stop or clear applies.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_count     <= '0;
            r_lap_count <= '0;
            r_view      <= 1'b0;
            r_view_idx  <= '0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_laps[i] <= '0;
        end else begin
            if (w_evt[1]) begin
                if (r_state == S_RUN) begin
                    if (r_lap_count < 4'(LAP_DEPTH)) begin
                        r_laps[r_lap_count[VW-1:0]] <= r_count;
                        r_lap_count <= r_lap_count + 4'd1;
                    end
                end else if (r_state == S_STOP && r_lap_count != 4'd0) begin
                    if (!r_view) begin
                        r_view     <= 1'b1;
                        r_view_idx <= '0;
                    end else if (4'(r_view_idx) == r_lap_count - 4'd1) begin
                        r_view_idx <= '0;
                    end else begin
                        r_view_idx <= r_view_idx + VW'(1);
                    end
                end
            end

            if (i_dbg_load) begin
                r_count <= i_dbg_value;
            end else if (w_tick) begin
                r_count <= w_next_count;
                if (w_wrap) r_overflow <= 1'b1;
            end

            if (r_state == S_RUN) r_presc <= w_tick ? '0 : r_presc + PW'(1);

            if (w_evt[0]) begin
                r_view <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_RUN;
                        r_presc <= '0;
                    end
                    S_RUN:   r_state <= S_STOP;
                    S_STOP:  r_state <= S_RUN;
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_evt[2] && r_state != S_RUN) begin
                r_state     <= S_IDLE;
                r_presc     <= '0;
                r_count     <= '0;
                r_lap_count <= '0;
                r_view      <= 1'b0;
                r_view_idx  <= '0;
                r_overflow  <= 1'b0;
                for (int i = 0; i < LAP_DEPTH; i++) r_laps[i] <= '0;
            end
        end
    end

    // Digit scan: SCAN_DIV cycles per slot, digits 0..NUM_DIGITS-1 in order.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_scan_dig <= '0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_dig <= (r_scan_dig == DW'(NUM_DIGITS - 1)) ? '0 : r_scan_dig + DW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    // Select the shown value and decode the current digit; codes above 9 blank everything.
    always_comb begin
        w_disp_value = r_view ? r_laps[r_view_idx] : r_count;
        w_disp_digit = w_disp_value[{r_scan_dig, 2'b00} +: 4];
        w_dp_on      = (int'(r_scan_dig) == 2) || (TIME_FMT == 1 && int'(r_scan_dig) == 4);
        if (w_disp_digit > 4'd9) w_seg_next = 8'hFF;
        else                     w_seg_next = {~w_dp_on, ~seg7(w_disp_digit)};
    end

    // Registered display drivers so both are all-ones while in reset.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digits   <= '1;
            r_segments <= 8'hFF;
        end else begin
            r_digits   <= ~(NUM_DIGITS'(1) << r_scan_dig);
            r_segments <= w_seg_next;
        end
    end

    assign o_segments  = r_segments;
    assign o_digits    = r_digits;
    assign o_running   = (r_state == S_RUN);
    assign o_lap_count = r_lap_count;
    assign o_overflow  = r_overflow;
    assign o_dbg_state = r_state;
    assign o_dbg_count = r_count;

endmodule
